// File: rtl/qerv_mdu_serial.sv
// qerv_mdu_serial
// ---------------
// Multi-cycle M-extension unit that sits beside the core on its MDU port.
// The core raises i_mdu_valid with both operands and funct3. The unit then
// computes the result one bit per clock and reports it with a single-cycle
// o_mdu_ready pulse.
//
// Multiply uses a 64-bit shift-add that takes the multiplier LSB first.
// Divide uses a restoring divider that produces the quotient MSB first.
// Both run on unsigned magnitudes. The sign is fixed up on the final
// iteration.
//
// Build option:
//   QERV_MDU_DIV_EN  defined   -> full divider (DIV/DIVU/REM/REMU)
//                    undefined -> no divider; funct3[2]=1 completes
//                                 at once with a zero result
//
// Parameters:
//   RESET_STRATEGY   "MINI" : o_mdu_rd is cleared by reset
//                    "NONE" : o_mdu_rd is left unreset
//   The FSM state, the counter and o_mdu_ready are always reset.
//   The operand and accumulator registers are never reset.
//
// Ports:
//   clk           clock
//   i_rst         asynchronous active-high reset
//   i_mdu_valid   request, held with stable operands until ready
//   i_mdu_rs1     operand A
//   i_mdu_rs2     operand B
//   i_mdu_funct3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   o_mdu_rd      result, valid while o_mdu_ready is high
//   o_mdu_ready   one-cycle completion pulse (registered)

module qerv_mdu_serial #(
  parameter RESET_STRATEGY = "MINI"
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_mdu_valid,
  input  logic [31:0] i_mdu_rs1,
  input  logic [31:0] i_mdu_rs2,
  input  logic [2:0]  i_mdu_funct3,
  output logic [31:0] o_mdu_rd,
  output logic        o_mdu_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  counter;

  logic [31:0] opnd;
  logic [63:0] prod;
  logic        neg;
  logic [1:0]  op;
`ifdef QERV_MDU_DIV_EN
  logic        is_div;
`endif

  logic        accept;
  logic        step;
  logic        last;

  logic        rs1_signed;
  logic        rs2_signed;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic        neg_in;
  logic        special;
  logic [31:0] special_rd;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
`ifdef QERV_MDU_DIV_EN
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] div_sel;
`endif
  logic [63:0] step_next;
  logic [63:0] signed_prod;
  logic [31:0] final_rd;

  logic        rd_load;
  logic [31:0] rd_value;

  // Request decode. This works out which operands are taken as signed and
  // whether the final magnitude must be negated. MUL keeps raw operands and
  // never negates, because the low product word is the same for signed and
  // unsigned operands.
  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    neg_in     = 1'b0;
    case (i_mdu_funct3)
      3'd1: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
        neg_in     = i_mdu_rs1[31] ^ i_mdu_rs2[31];
      end
      3'd2: begin
        rs1_signed = 1'b1;
        neg_in     = i_mdu_rs1[31];
      end
      3'd4: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
        neg_in     = i_mdu_rs1[31] ^ i_mdu_rs2[31];
      end
      3'd6: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
        neg_in     = i_mdu_rs1[31];
      end
      default: begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        neg_in     = 1'b0;
      end
    endcase
    rs1_mag = (rs1_signed && i_mdu_rs1[31]) ? (32'd0 - i_mdu_rs1) : i_mdu_rs1;
    rs2_mag = (rs2_signed && i_mdu_rs2[31]) ? (32'd0 - i_mdu_rs2) : i_mdu_rs2;
  end

  // Operations whose result is known at acceptance skip the CALC state.
  always_comb begin
    special    = 1'b0;
    special_rd = 32'd0;
`ifdef QERV_MDU_DIV_EN
    if (i_mdu_funct3[2]) begin
      if (i_mdu_rs2 == 32'd0) begin
        special    = 1'b1;
        special_rd = i_mdu_funct3[1] ? i_mdu_rs1 : 32'hFFFF_FFFF;
      end else if (!i_mdu_funct3[0] && i_mdu_rs1 == 32'h8000_0000 &&
                   i_mdu_rs2 == 32'hFFFF_FFFF) begin
        special    = 1'b1;
        special_rd = i_mdu_funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
`else
    special    = i_mdu_funct3[2];
    special_rd = 32'd0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic. DONE always returns to IDLE, so a valid that is
  // still high on the edge leaving DONE cannot start a second operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_mdu_valid) state_next = special ? DONE : CALC;
      CALC:    if (counter == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode. These are the control strobes for the datapath.
  always_comb begin
    accept = (state == IDLE) && i_mdu_valid;
    step   = (state == CALC);
    last   = (state == CALC) && (counter == 5'd31);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      counter     <= 5'd0;
      o_mdu_ready <= 1'b0;
    end else begin
      if (accept)    counter <= 5'd0;
      else if (step) counter <= counter + 5'd1;
      o_mdu_ready <= (state_next == DONE);
    end
  end

  // One iteration of each algorithm. prod holds {acc_hi, multiplier} for a
  // multiply and {partial_remainder, dividend/quotient} for a divide.
  // The partial remainder plus the incoming dividend bit needs 33 bits. One
  // extra bit on top of that exposes the borrow of the trial subtraction.
  always_comb begin
    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, prod[31:1]};
`ifdef QERV_MDU_DIV_EN
    div_diff = {1'b0, prod[63:31]} - {2'b00, opnd};
    div_next = div_diff[33] ? {prod[62:0], 1'b0}
                            : {div_diff[31:0], prod[30:0], 1'b1};
`endif
    step_next = mul_next;
`ifdef QERV_MDU_DIV_EN
    if (is_div) step_next = div_next;
`endif
    signed_prod = neg ? (64'd0 - step_next) : step_next;
    final_rd    = (op == 2'b00) ? signed_prod[31:0] : signed_prod[63:32];
`ifdef QERV_MDU_DIV_EN
    div_sel = op[1] ? step_next[63:32] : step_next[31:0];
    if (is_div) final_rd = neg ? (32'd0 - div_sel) : div_sel;
`endif
  end

  // Unreset datapath. All inputs are captured at acceptance, so later
  // changes to the operands or funct3 have no effect.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg <= neg_in;
      op  <= i_mdu_funct3[1:0];
`ifdef QERV_MDU_DIV_EN
      is_div <= i_mdu_funct3[2];
      opnd   <= i_mdu_funct3[2] ? rs2_mag : rs1_mag;
      prod   <= {32'd0, (i_mdu_funct3[2] ? rs1_mag : rs2_mag)};
`else
      opnd <= rs1_mag;
      prod <= {32'd0, rs2_mag};
`endif
    end else if (step) begin
      prod <= step_next;
    end
  end

  always_comb begin
    rd_load  = (accept && special) || last;
    rd_value = accept ? special_rd : final_rd;
  end

  generate
    if (RESET_STRATEGY == "NONE") begin : g_rd_noreset
      always_ff @(posedge clk) begin
        if (rd_load) o_mdu_rd <= rd_value;
      end
    end else begin : g_rd_reset
      always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst)        o_mdu_rd <= 32'd0;
        else if (rd_load) o_mdu_rd <= rd_value;
      end
    end
  endgenerate

endmodule

// File: tb/tb_qerv_mdu_serial.sv
// Testbench for qerv_mdu_serial (default RESET_STRATEGY "MINI").
// Expected results come from a reference model that uses plain 64-bit
// arithmetic. Expected latency comes from the special-case rules. The
// divider expectations follow the QERV_MDU_DIV_EN build option.

module tb_qerv_mdu_serial;

`ifdef QERV_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        i_rst;
  logic        mdu_valid;
  logic [31:0] mdu_rs1;
  logic [31:0] mdu_rs2;
  logic [2:0]  mdu_funct3;
  logic [31:0] mdu_rd;
  logic        mdu_ready;

  int checks;
  int failures;

  qerv_mdu_serial dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_mdu_valid  (mdu_valid),
    .i_mdu_rs1    (mdu_rs1),
    .i_mdu_rs2    (mdu_rs2),
    .i_mdu_funct3 (mdu_funct3),
    .o_mdu_rd     (mdu_rd),
    .o_mdu_ready  (mdu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the architectural result of each M-extension op.
  function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    if (f3[2] && !DIV_EN) return 32'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2]) return 33;
    if (!DIV_EN) return 1;
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Drives one request and waits (bounded) for the ready pulse.
  // lat counts clock cycles from acceptance (edge E0). The result is 1 when
  // ready is visible just after E0. ready_after samples ready one edge later
  // to show the pulse width.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit keep_valid,
                        input bit scramble, output logic [31:0] rd,
                        output int lat, output bit seen,
                        output logic ready_after);
    mdu_valid  = 1'b1;
    mdu_funct3 = f3;
    mdu_rs1    = a;
    mdu_rs2    = b;
    @(posedge clk);
    #1;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mdu_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (scramble) begin
        mdu_rs1    = $urandom;
        mdu_rs2    = $urandom;
        mdu_funct3 = 3'($urandom_range(0, 7));
      end
      @(posedge clk);
      #1;
      lat++;
    end
    rd = mdu_rd;
    mdu_valid = keep_valid;
    @(posedge clk);
    #1;
    ready_after = mdu_ready;
  endtask

  task automatic test_reset;
    i_rst      = 1'b1;
    mdu_valid  = 1'b0;
    mdu_rs1    = 32'd0;
    mdu_rs2    = 32'd0;
    mdu_funct3 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mdu_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b want=0", mdu_ready);
    end
    checks++;
    if (mdu_rd !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_rd got=%h want=00000000", mdu_rd);
    end
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [2:0]  f3  [14];
    logic [31:0] va  [14];
    logic [31:0] vb  [14];
    logic [31:0] exp [14];
    int          elat[14];
    logic [31:0] rd;
    int          lat;
    bit          seen;
    logic        rafter;
    f3[0]  = 3'd0; va[0]  = 32'd7;          vb[0]  = 32'hFFFF_FFFD; exp[0]  = 32'hFFFF_FFEB; elat[0]  = 33;
    f3[1]  = 3'd1; va[1]  = 32'h8000_0000;  vb[1]  = 32'h8000_0000; exp[1]  = 32'h4000_0000; elat[1]  = 33;
    f3[2]  = 3'd2; va[2]  = 32'hFFFF_FFFF;  vb[2]  = 32'hFFFF_FFFF; exp[2]  = 32'hFFFF_FFFF; elat[2]  = 33;
    f3[3]  = 3'd3; va[3]  = 32'hFFFF_FFFF;  vb[3]  = 32'hFFFF_FFFF; exp[3]  = 32'hFFFF_FFFE; elat[3]  = 33;
    f3[4]  = 3'd4; va[4]  = 32'hFFFF_FFF9;  vb[4]  = 32'd2;         exp[4]  = 32'hFFFF_FFFD; elat[4]  = 33;
    f3[5]  = 3'd6; va[5]  = 32'hFFFF_FFF9;  vb[5]  = 32'd2;         exp[5]  = 32'hFFFF_FFFF; elat[5]  = 33;
    f3[6]  = 3'd5; va[6]  = 32'd100;        vb[6]  = 32'd7;         exp[6]  = 32'd14;        elat[6]  = 33;
    f3[7]  = 3'd7; va[7]  = 32'd100;        vb[7]  = 32'd7;         exp[7]  = 32'd2;         elat[7]  = 33;
    f3[8]  = 3'd5; va[8]  = 32'h1234_5678;  vb[8]  = 32'd0;         exp[8]  = 32'hFFFF_FFFF; elat[8]  = 1;
    f3[9]  = 3'd6; va[9]  = 32'h0000_1234;  vb[9]  = 32'd0;         exp[9]  = 32'h0000_1234; elat[9]  = 1;
    f3[10] = 3'd4; va[10] = 32'h8000_0000;  vb[10] = 32'hFFFF_FFFF; exp[10] = 32'h8000_0000; elat[10] = 1;
    f3[11] = 3'd6; va[11] = 32'h8000_0000;  vb[11] = 32'hFFFF_FFFF; exp[11] = 32'h0000_0000; elat[11] = 1;
    f3[12] = 3'd4; va[12] = 32'd10;         vb[12] = 32'd2;         exp[12] = 32'd5;         elat[12] = 33;
    f3[13] = 3'd0; va[13] = 32'd6;          vb[13] = 32'd7;         exp[13] = 32'd42;        elat[13] = 33;
    for (int i = 0; i < 14; i++) begin
      if (f3[i][2] && !DIV_EN) begin
        exp[i]  = 32'd0;
        elat[i] = 1;
      end
      run_op(f3[i], va[i], vb[i], 1'b0, 1'b0, rd, lat, seen, rafter);
      checks++;
      if (!seen) begin
        failures++;
        $display("[TB] FAIL directed%0d_timeout ready never seen", i);
      end
      checks++;
      if (rd !== exp[i]) begin
        failures++;
        $display("[TB] FAIL directed%0d_rd f3=%0d got=%h want=%h", i, f3[i], rd, exp[i]);
      end
      checks++;
      if (lat != elat[i]) begin
        failures++;
        $display("[TB] FAIL directed%0d_latency got=%0d want=%0d", i, lat, elat[i]);
      end
      checks++;
      if (rafter !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed%0d_pulse_width ready_after=%b want=0", i, rafter);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // scramble=1 also changes the operands and funct3 while CALC is running.
  task automatic test_random(input int n, input bit scramble);
    logic [2:0]  f3;
    logic [31:0] a, b, rd;
    int          lat;
    bit          seen;
    logic        rafter;
    for (int i = 0; i < n; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, 1'b0, scramble, rd, lat, seen, rafter);
      checks++;
      if (rd !== ref_result(f3, a, b) || lat != ref_latency(f3, a, b)) begin
        failures++;
        $display("[TB] FAIL random%0d f3=%0d a=%h b=%h got=%h/%0d want=%h/%0d",
                 i, f3, a, b, rd, lat, ref_result(f3, a, b), ref_latency(f3, a, b));
      end
    end
  endtask

  // Valid stays high across the edge leaving DONE, and the next request is
  // presented at once. It must be taken one edge later with normal latency.
  task automatic test_back_to_back;
    logic [2:0]  f3;
    logic [31:0] a, b, rd;
    int          lat;
    bit          seen;
    logic        rafter;
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(f3, a, b, 1'b1, 1'b0, rd, lat, seen, rafter);
      checks++;
      if (rd !== ref_result(f3, a, b) || lat != ref_latency(f3, a, b) || rafter !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b%0d f3=%0d a=%h b=%h got=%h/%0d/%b want=%h/%0d/0",
                 i, f3, a, b, rd, lat, rafter, ref_result(f3, a, b), ref_latency(f3, a, b));
      end
    end
    mdu_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold;
    logic [31:0] rd;
    int          lat;
    bit          seen;
    logic        rafter;
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, rd, lat, seen, rafter);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mdu_rd !== ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678) || mdu_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_rd got=%h ready=%b want=%h ready=0", mdu_rd, mdu_ready,
               ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    end
  endtask

  task automatic test_reset_mid_op;
    int          pulses;
    logic [31:0] rd;
    int          lat;
    bit          seen;
    logic        rafter;
    mdu_valid  = 1'b1;
    mdu_funct3 = 3'd0;
    mdu_rs1    = 32'h0001_0003;
    mdu_rs2    = 32'h0000_0005;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (mdu_rd !== 32'd0 || mdu_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_async_reset rd=%h ready=%b want rd=00000000 ready=0",
               mdu_rd, mdu_ready);
    end
    mdu_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mdu_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("[TB] FAIL midop_no_ready pulses=%0d want=0", pulses);
    end
    run_op(3'd5, 32'd9, 32'd3, 1'b0, 1'b0, rd, lat, seen, rafter);
    checks++;
    if (rd !== (DIV_EN ? 32'd3 : 32'd0) || lat != (DIV_EN ? 33 : 1)) begin
      failures++;
      $display("[TB] FAIL midop_next_divu got=%h/%0d want=%h/%0d", rd, lat,
               DIV_EN ? 32'd3 : 32'd0, DIV_EN ? 33 : 1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random(60, 1'b0);
    test_random(10, 1'b1);
    test_back_to_back();
    test_hold();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
